// File: rtl/xfer_sequencer.sv
// Register-transfer sequencer: turns one command into a timed pattern of active-low
// per-register strobes, with a done pulse on completion and an err pulse on rejection.
module xfer_sequencer #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned ADDR_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [SEL_W-1:0]    cmd_src_i,
  input  logic [SEL_W-1:0]    cmd_dst_i,
  output logic [NUM_REGS-1:0] assert_addr_o,
  output logic [NUM_REGS-1:0] assert_xfer_o,
  output logic [NUM_REGS-1:0] load_xfer_o,
  output logic [NUM_REGS-1:0] assertlow_main_o,
  output logic [NUM_REGS-1:0] asserthigh_main_o,
  output logic [NUM_REGS-1:0] loadlow_main_o,
  output logic [NUM_REGS-1:0] loadhigh_main_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [1:0] OpXfer    = 2'b00;
  localparam logic [1:0] OpLoad16  = 2'b01;
  localparam logic [1:0] OpStore16 = 2'b10;
  localparam logic [1:0] OpAddr    = 2'b11;

  localparam logic [SEL_W:0] NumRegsW = (SEL_W + 1)'(NUM_REGS);
  localparam logic [3:0]     AddrLast = 4'(ADDR_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StXfer, StLo, StHi, StAddr} state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic [SEL_W-1:0]    src_q, dst_q;
  logic [3:0]          cnt_q;
  logic [NUM_REGS-1:0] assert_addr_q, assert_xfer_q, load_xfer_q;
  logic [NUM_REGS-1:0] assertlow_main_q, asserthigh_main_q, loadlow_main_q, loadhigh_main_q;
  logic                done_q, err_q;

  logic src_ok, dst_ok, illegal;

  always_comb begin
    src_ok  = {1'b0, cmd_src_i} < NumRegsW;
    dst_ok  = {1'b0, cmd_dst_i} < NumRegsW;
    illegal = 1'b0;
    unique case (cmd_op_i)
      OpXfer:    illegal = !src_ok || !dst_ok || (cmd_src_i == cmd_dst_i);
      OpLoad16:  illegal = !dst_ok;
      OpStore16: illegal = !src_ok;
      OpAddr:    illegal = !src_ok;
      default:   illegal = 1'b1;
    endcase
  end

  // Strobes default high every cycle; each state clears only the bits for the next cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      op_q              <= OpXfer;
      src_q             <= '0;
      dst_q             <= '0;
      cnt_q             <= '0;
      assert_addr_q     <= '1;
      assert_xfer_q     <= '1;
      load_xfer_q       <= '1;
      assertlow_main_q  <= '1;
      asserthigh_main_q <= '1;
      loadlow_main_q    <= '1;
      loadhigh_main_q   <= '1;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      assert_addr_q     <= '1;
      assert_xfer_q     <= '1;
      load_xfer_q       <= '1;
      assertlow_main_q  <= '1;
      asserthigh_main_q <= '1;
      loadlow_main_q    <= '1;
      loadhigh_main_q   <= '1;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            op_q  <= cmd_op_i;
            src_q <= cmd_src_i;
            dst_q <= cmd_dst_i;
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              unique case (cmd_op_i)
                OpXfer: begin
                  state_q                  <= StXfer;
                  assert_xfer_q[cmd_src_i] <= 1'b0;
                  load_xfer_q[cmd_dst_i]   <= 1'b0;
                end
                OpLoad16: begin
                  state_q                   <= StLo;
                  loadlow_main_q[cmd_dst_i] <= 1'b0;
                end
                OpStore16: begin
                  state_q                     <= StLo;
                  assertlow_main_q[cmd_src_i] <= 1'b0;
                end
                default: begin
                  state_q                  <= StAddr;
                  cnt_q                    <= AddrLast;
                  assert_addr_q[cmd_src_i] <= 1'b0;
                end
              endcase
            end
          end
        end
        StXfer: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        StLo: begin
          state_q <= StHi;
          if (op_q == OpLoad16) loadhigh_main_q[dst_q] <= 1'b0;
          else                  asserthigh_main_q[src_q] <= 1'b0;
        end
        StHi: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        StAddr: begin
          if (cnt_q == 4'd0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q                <= cnt_q - 4'd1;
            assert_addr_q[src_q] <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o       = (state_q == StIdle);
  assign assert_addr_o     = assert_addr_q;
  assign assert_xfer_o     = assert_xfer_q;
  assign load_xfer_o       = load_xfer_q;
  assign assertlow_main_o  = assertlow_main_q;
  assign asserthigh_main_o = asserthigh_main_q;
  assign loadlow_main_o    = loadlow_main_q;
  assign loadhigh_main_o   = loadhigh_main_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Self-checking bench for xfer_sequencer: each scenario queues expected per-cycle output
// frames and pops one per cycle against the sampled outputs.
module tb_xfer_sequencer;

  localparam int unsigned NumRegs    = 4;
  localparam int unsigned SelW       = 2;
  localparam int unsigned AddrCycles = 2;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic [1:0]         cmd_op_i = 2'b00;
  logic [SelW-1:0]    cmd_src_i = '0;
  logic [SelW-1:0]    cmd_dst_i = '0;
  logic [NumRegs-1:0] assert_addr_o, assert_xfer_o, load_xfer_o;
  logic [NumRegs-1:0] assertlow_main_o, asserthigh_main_o, loadlow_main_o, loadhigh_main_o;
  logic               done_o, err_o;

  int total = 0;
  int bad = 0;
  logic [30:0] sb_q[$];
  logic [30:0] got, exp;

  xfer_sequencer #(
    .NUM_REGS   (NumRegs),
    .SEL_W      (SelW),
    .ADDR_CYCLES(AddrCycles)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_op_i         (cmd_op_i),
    .cmd_src_i        (cmd_src_i),
    .cmd_dst_i        (cmd_dst_i),
    .assert_addr_o    (assert_addr_o),
    .assert_xfer_o    (assert_xfer_o),
    .load_xfer_o      (load_xfer_o),
    .assertlow_main_o (assertlow_main_o),
    .asserthigh_main_o(asserthigh_main_o),
    .loadlow_main_o   (loadlow_main_o),
    .loadhigh_main_o  (loadhigh_main_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Frame: {ready, done, err, addr, xfer, load_xfer, alo, ahi, llo, lhi}
  function automatic logic [30:0] obs();
    return {cmd_ready_o, done_o, err_o, assert_addr_o, assert_xfer_o, load_xfer_o,
            assertlow_main_o, asserthigh_main_o, loadlow_main_o, loadhigh_main_o};
  endfunction

  // vec selects the strobe vector (0=addr .. 6=loadhigh) with bit b low; vec<0 means none.
  function automatic logic [30:0] fr(input logic rdy, input logic dn, input logic er,
                                     input int vec, input int b);
    logic [30:0] w;
    w = {rdy, dn, er, 28'hFFF_FFFF};
    if (vec >= 0) w[(6 - vec) * 4 + b] = 1'b0;
    return w;
  endfunction

  task automatic issue(input logic [1:0] op, input int s, input int d);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_src_i   = SelW'(s);
    cmd_dst_i   = SelW'(d);
  endtask

  task automatic test_reset();
    issue(2'b00, 0, 1);
    repeat (3) begin
      @(negedge clk_i);
      got = obs();
      exp = fr(1'b1, 1'b0, 1'b0, -1, 0);
      total++;
      if (got[29:0] !== exp[29:0]) begin
        bad++;
        $display("FAIL reset_hold got=%h exp=%h", got[29:0], exp[29:0]);
      end
    end
    cmd_valid_i = 1'b0;
    rst_ni      = 1'b1;
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_release got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_xfer(input int s, input int d);
    @(negedge clk_i);
    issue(2'b00, s, d);
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 1, s) & fr(1'b0, 1'b0, 1'b0, 2, d));
    sb_q.push_back(fr(1'b1, 1'b1, 1'b0, -1, 0));
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL xfer got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_load16();
    @(negedge clk_i);
    issue(2'b01, 0, 3);
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 5, 3));
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 6, 3));
    sb_q.push_back(fr(1'b1, 1'b1, 1'b0, -1, 0));
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL load16 got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    issue(2'b10, 0, 0);
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 3, 0));
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 4, 0));
    sb_q.push_back(fr(1'b1, 1'b1, 1'b0, -1, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_store cycle=%0d got=%h exp=%h", i, got, exp);
      end
    end
    // Second command issued in the done cycle of the first.
    issue(2'b11, 2, 0);
    for (int i = 0; i < AddrCycles; i++) sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 0, 2));
    sb_q.push_back(fr(1'b1, 1'b1, 1'b0, -1, 0));
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_addr got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_illegal();
    @(negedge clk_i);
    issue(2'b00, 2, 2);
    sb_q.push_back(fr(1'b1, 1'b0, 1'b1, -1, 0));
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL illegal got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk_i);
    issue(2'b01, 0, 1);
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 5, 1));
    sb_q.push_back(fr(1'b0, 1'b0, 1'b0, 6, 1));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL abort_run got=%h exp=%h", got, exp);
      end
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    got = obs();
    exp = fr(1'b1, 1'b0, 1'b0, -1, 0);
    total++;
    if (got[29:0] !== exp[29:0]) begin
      bad++;
      $display("FAIL abort_reset got=%h exp=%h", got[29:0], exp[29:0]);
    end
    rst_ni = 1'b1;
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    sb_q.push_back(fr(1'b1, 1'b0, 1'b0, -1, 0));
    while (sb_q.size() != 0) begin
      @(negedge clk_i);
      got = obs();
      exp = sb_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL abort_after got=%h exp=%h", got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xfer(1, 2);
    test_load16();
    test_back_to_back();
    test_illegal();
    test_abort();
    test_xfer(0, 1);
    test_xfer(3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
